io_data_mem: RTL and testbench

- Data-side memory stage that consumes the pipeline's MEM-stage outputs (ALU address, store data, write enable) and returns load data.
- Contains a word-addressed data RAM plus a memory-mapped I/O region:
  - two synchronised input ports
  - two output registers
  - a free-running cycle counter
  - an auto-reload down-counting timer with a sticky flag.
- Read is combinational so load data is valid within the same MEM cycle for forwarding and for capture into the MEM/WB register.

---
 rtl/io_data_mem.sv | 141 ++++++++++++++
 tb/tb_io_data_mem.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_data_mem.sv
// io_data_mem: MEM-stage data RAM plus a memory-mapped I/O block.
// Ports: clock/reset, addr/wdata/we, rdata (comb), in_port0/1, out_port0/1, timer_flag.
module io_data_mem #(
  parameter int RAM_AW = 6,
  parameter int IN_W   = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  input  logic            we,
  output logic [31:0]     rdata,
  input  logic [IN_W-1:0] in_port0,
  input  logic [IN_W-1:0] in_port1,
  output logic [31:0]     out_port0,
  output logic [31:0]     out_port1,
  output logic            timer_flag
);

  localparam int Depth = 1 << RAM_AW;

  localparam logic [5:0] OffIn0  = 6'd0;
  localparam logic [5:0] OffIn1  = 6'd1;
  localparam logic [5:0] OffOut0 = 6'd2;
  localparam logic [5:0] OffOut1 = 6'd3;
  localparam logic [5:0] OffCnt  = 6'd4;
  localparam logic [5:0] OffRld  = 6'd5;
  localparam logic [5:0] OffStat = 6'd6;
  localparam logic [5:0] OffTcnt = 6'd7;

  logic              io_sel;
  logic [5:0]        woff;
  logic [RAM_AW-1:0] idx;
  logic              unused_abits;

  // I/O offsets are word-decoded; byte-lane bits are ignored everywhere.
  assign io_sel       = (addr[31:8] == 24'hFFFFFF);
  assign woff         = addr[7:2];
  assign idx          = addr[RAM_AW+1:2];
  assign unused_abits = ^addr[1:0];

  logic [31:0] ram_q [Depth];
  logic        ram_we;

  assign ram_we = we && !io_sel && !reset;

  always_ff @(posedge clock) begin
    if (ram_we) begin
      ram_q[idx] <= wdata;
    end
  end

  logic [IN_W-1:0] in0_meta_q, in0_q;
  logic [IN_W-1:0] in1_meta_q, in1_q;
  logic [31:0]     out0_q, out0_d;
  logic [31:0]     out1_q, out1_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [31:0]     rld_q, rld_d;
  logic [31:0]     tcnt_q, tcnt_d;
  logic            flag_q, flag_d;
  logic            wr_io, wr_rld, expire;

  assign wr_io  = we && io_sel;
  assign wr_rld = wr_io && (woff == OffRld);
  // A reload write restarts the timer and masks the expiry that cycle.
  assign expire = !wr_rld && (rld_q != '0) && (tcnt_q == '0);

  always_comb begin
    out0_d = out0_q;
    out1_d = out1_q;
    cnt_d  = cnt_q + 32'd1;
    rld_d  = rld_q;
    tcnt_d = tcnt_q;
    flag_d = flag_q;
    if (wr_io && woff == OffOut0) out0_d = wdata;
    if (wr_io && woff == OffOut1) out1_d = wdata;
    if (wr_io && woff == OffCnt)  cnt_d  = wdata;
    if (wr_rld) begin
      rld_d  = wdata;
      tcnt_d = wdata;
    end else if (rld_q != '0) begin
      tcnt_d = (tcnt_q == '0) ? rld_q : tcnt_q - 32'd1;
    end
    // Set beats a simultaneous W1C clear.
    if (expire) begin
      flag_d = 1'b1;
    end else if (wr_io && woff == OffStat && wdata[0]) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in0_meta_q <= '0;
      in0_q      <= '0;
      in1_meta_q <= '0;
      in1_q      <= '0;
      out0_q     <= '0;
      out1_q     <= '0;
      cnt_q      <= '0;
      rld_q      <= '0;
      tcnt_q     <= '0;
      flag_q     <= 1'b0;
    end else begin
      in0_meta_q <= in_port0;
      in0_q      <= in0_meta_q;
      in1_meta_q <= in_port1;
      in1_q      <= in1_meta_q;
      out0_q     <= out0_d;
      out1_q     <= out1_d;
      cnt_q      <= cnt_d;
      rld_q      <= rld_d;
      tcnt_q     <= tcnt_d;
      flag_q     <= flag_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (!io_sel) begin
      rdata = ram_q[idx];
    end else begin
      case (woff)
        OffIn0:  rdata = 32'(in0_q);
        OffIn1:  rdata = 32'(in1_q);
        OffOut0: rdata = out0_q;
        OffOut1: rdata = out1_q;
        OffCnt:  rdata = cnt_q;
        OffRld:  rdata = rld_q;
        OffStat: rdata = {31'b0, flag_q};
        OffTcnt: rdata = tcnt_q;
        default: rdata = '0;
      endcase
    end
  end

  assign out_port0  = out0_q;
  assign out_port1  = out1_q;
  assign timer_flag = flag_q;

endmodule

// File: tb/tb_io_data_mem.sv
// tb_io_data_mem: random + directed bench for io_data_mem
// against a closed-form behavioural model.
module tb_io_data_mem;
  localparam int AW = 6;
  localparam int IW = 8;
  localparam int HN = 8192;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   addr  = '0;
  logic [31:0]   wdata = '0;
  logic          we    = 1'b0;
  logic [31:0]   rdata, out_port0, out_port1;
  logic [IW-1:0] in_port0 = '0;
  logic [IW-1:0] in_port1 = '0;
  logic          timer_flag;

  int cmp_n = 0;
  int bad_n = 0;

  always #5 clock = ~clock;

  io_data_mem #(.RAM_AW(AW), .IN_W(IW)) dut (
    .clock     (clock),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .rdata     (rdata),
    .in_port0  (in_port0),
    .in_port1  (in_port1),
    .out_port0 (out_port0),
    .out_port1 (out_port1),
    .timer_flag(timer_flag)
  );

  // Model: counter and timer are kept as (base value, edge index)
  // and evaluated in closed form at the current edge count m_n.
  logic [31:0]   m_ram [64];
  bit            m_known [64];
  logic [31:0]   m_out0, m_out1, m_cbase, m_rld;
  int            m_n = 0, m_ct = 0, m_rt = 0, m_rst = -10;
  bit            m_flag = 0, m_live = 0;
  logic [IW-1:0] m_p0 [HN];
  logic [IW-1:0] m_p1 [HN];

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    cmp_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_tcnt();
    longint el;
    if (m_rld == 0) return 32'd0;
    el = longint'(m_n - m_rt) % (longint'(m_rld) + 1);
    return m_rld - 32'(el);
  endfunction

  // Synchronised value after edge n is the pin sampled at edge n-1.
  function automatic logic [31:0] m_pin(bit which);
    if (m_n - 1 <= m_rst) return 32'd0;
    if (which) return 32'(m_p1[(m_n - 1) % HN]);
    return 32'(m_p0[(m_n - 1) % HN]);
  endfunction

  function automatic logic [31:0] m_rdata(logic [31:0] a);
    logic [5:0] o;
    if (a[31:8] != 24'hFFFFFF) return m_ram[a[AW+1:2]];
    o = a[7:2];
    case (o)
      6'd0: return m_pin(0);
      6'd1: return m_pin(1);
      6'd2: return m_out0;
      6'd3: return m_out1;
      6'd4: return m_cbase + 32'(m_n - m_ct);
      6'd5: return m_rld;
      6'd6: return {31'b0, m_flag};
      6'd7: return m_tcnt();
      default: return 32'd0;
    endcase
  endfunction

  // Apply the inputs that the next rising edge will sample.
  task automatic model_step();
    int         n1;
    bit         io, w, ex;
    logic [5:0] o;
    n1 = m_n + 1;
    io = (addr[31:8] == 24'hFFFFFF);
    w  = we && io;
    o  = addr[7:2];
    if (reset) begin
      m_out0  = 0;
      m_out1  = 0;
      m_cbase = 0;
      m_ct    = n1;
      m_rld   = 0;
      m_rt    = n1;
      m_flag  = 0;
      m_rst   = n1;
      m_live  = 1;
    end else begin
      ex = (m_rld != 0) && !(w && o == 6'd5) &&
           ((longint'(n1 - m_rt) % (longint'(m_rld) + 1)) == 0);
      if (we && !io) begin
        m_ram[addr[AW+1:2]]   = wdata;
        m_known[addr[AW+1:2]] = 1;
      end
      if (w && o == 6'd2) m_out0 = wdata;
      if (w && o == 6'd3) m_out1 = wdata;
      if (w && o == 6'd4) begin
        m_cbase = wdata;
        m_ct    = n1;
      end
      if (w && o == 6'd5) begin
        m_rld = wdata;
        m_rt  = n1;
      end
      if (ex) m_flag = 1;
      else if (w && o == 6'd6 && wdata[0]) m_flag = 0;
    end
    m_p0[n1 % HN] = in_port0;
    m_p1[n1 % HN] = in_port1;
    m_n = n1;
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (m_live) begin
        chk("out_port0", out_port0, m_out0);
        chk("out_port1", out_port1, m_out1);
        chk("timer_flag", 32'(timer_flag), 32'(m_flag));
        if (addr[31:8] == 24'hFFFFFF || m_known[addr[AW+1:2]])
          chk("rdata", rdata, m_rdata(addr));
      end
      model_step();
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drv(logic [31:0] a, logic [31:0] d, logic w);
    addr  = a;
    wdata = d;
    we    = w;
  endtask

  task automatic peek(string nm, logic [31:0] got, logic [31:0] exp);
    #1;
    chk(nm, got, exp);
  endtask

  logic [31:0] ra;
  logic [5:0]  ro;

  initial begin
    reset = 1;
    tick();
    tick();
    reset = 0;
    drv(32'hFFFFFF10, 0, 0);
    peek("rst_cnt", rdata, 32'd0);
    chk("rst_out0", out_port0, 32'd0);
    chk("rst_flag", 32'(timer_flag), 32'd0);

    for (int i = 0; i < 64; i++) begin
      drv(32'(i * 4), $urandom, 1);
      tick();
    end

    drv(32'h4, 32'h11111111, 1);
    tick();
    drv(32'h4, 32'hDEADBEEF, 1);
    peek("ram_rdw_old", rdata, 32'h11111111);
    tick();
    drv(32'h4, 0, 0);
    peek("ram_new", rdata, 32'hDEADBEEF);
    drv(32'h104, 0, 0);
    peek("ram_alias", rdata, 32'hDEADBEEF);

    drv(32'hFFFFFF08, 32'hA5, 1);
    tick();
    drv(32'hFFFFFF08, 0, 0);
    peek("out0_pin", out_port0, 32'hA5);
    peek("out0_rd", rdata, 32'hA5);
    reset = 1;
    drv(32'hFFFFFF08, 32'h5A, 1);
    tick();
    reset = 0;
    drv(32'hFFFFFF08, 0, 0);
    peek("out0_rst", out_port0, 32'd0);

    drv(32'hFFFFFF0C, 32'h1234, 1);
    tick();
    drv(32'hFFFFFF0C, 0, 0);
    peek("out1_pin", out_port1, 32'h1234);

    drv(32'hFFFFFF04, 0, 0);
    tick();
    tick();
    in_port1 = 8'h3C;
    peek("sync_e0", rdata, 32'd0);
    tick();
    peek("sync_e1", rdata, 32'd0);
    tick();
    peek("sync_e2", rdata, 32'h3C);

    drv(32'hFFFFFF14, 3, 1);
    tick();
    drv(32'hFFFFFF1C, 0, 0);
    peek("tcnt_3", rdata, 32'd3);
    tick();
    peek("tcnt_2", rdata, 32'd2);
    tick();
    peek("tcnt_1", rdata, 32'd1);
    tick();
    peek("tcnt_0", rdata, 32'd0);
    chk("flag_pre", 32'(timer_flag), 32'd0);
    tick();
    peek("flag_rise", 32'(timer_flag), 32'd1);
    chk("tcnt_rl", rdata, 32'd3);
    drv(32'hFFFFFF18, 1, 1);
    tick();
    drv(32'hFFFFFF18, 0, 0);
    peek("flag_clr", 32'(timer_flag), 32'd0);
    peek("stat_rd0", rdata, 32'd0);
    tick();
    tick();
    peek("flag_low", 32'(timer_flag), 32'd0);
    drv(32'hFFFFFF18, 1, 1);
    tick();
    drv(32'hFFFFFF18, 0, 0);
    peek("flag_setwins", 32'(timer_flag), 32'd1);
    peek("stat_rd1", rdata, 32'd1);
    drv(32'hFFFFFF14, 0, 1);
    tick();
    drv(32'hFFFFFF18, 1, 1);
    tick();
    drv(32'hFFFFFF1C, 0, 0);
    repeat (10) tick();
    peek("flag_off", 32'(timer_flag), 32'd0);
    peek("tcnt_off", rdata, 32'd0);

    drv(32'hFFFFFF10, 32'hFFFFFFFE, 1);
    tick();
    drv(32'hFFFFFF10, 0, 0);
    peek("cnt_fe", rdata, 32'hFFFFFFFE);
    tick();
    peek("cnt_ff", rdata, 32'hFFFFFFFF);
    tick();
    peek("cnt_wrap", rdata, 32'd0);

    drv(32'hFFFFFF20, 0, 0);
    peek("unmap_rd", rdata, 32'd0);
    drv(32'hFFFFFF20, 32'hFFFFFFFF, 1);
    tick();
    drv(32'hFFFFFF20, 0, 0);
    peek("unmap_out1", out_port1, 32'h1234);
    chk("unmap_out0", out_port0, 32'd0);
    chk("unmap_flag", 32'(timer_flag), 32'd0);

    repeat (3000) begin
      reset    = ($urandom_range(0, 199) == 0);
      in_port0 = IW'($urandom);
      in_port1 = IW'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        ra     = $urandom;
        ra[31] = 1'b0;
        drv(ra, $urandom, 1'($urandom));
      end else begin
        ro = 6'($urandom_range(0, 9));
        if (ro > 6'd7) ro = 6'($urandom);
        ra = {24'hFFFFFF, ro, 2'($urandom)};
        if (ro == 6'd5) drv(ra, $urandom_range(0, 6), 1'($urandom));
        else drv(ra, $urandom, 1'($urandom));
      end
      tick();
    end
    reset = 0;
    we    = 0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end

endmodule
